// File: rtl/serial_shift_rx_if.sv
// serial_shift_rx_if
// Bundles the serial line, the downstream valid/ready byte handshake and the
// status/LED outputs of serial_shift_rx.
//   master : receiver side (drives data_o/valid_o/flags/led_o, reads rx_in/ready_i)
//   slave  : board/consumer side (drives rx_in/ready_i, reads everything else)
interface serial_shift_rx_if;
    logic       rx_in;
    logic       ready_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       parity_err_o;
    logic [7:0] led_o;

    modport master (
        input  rx_in,
        input  ready_i,
        output data_o,
        output valid_o,
        output frame_err_o,
        output overrun_o,
        output parity_err_o,
        output led_o
    );

    modport slave (
        output rx_in,
        output ready_i,
        input  data_o,
        input  valid_o,
        input  frame_err_o,
        input  overrun_o,
        input  parity_err_o,
        input  led_o
    );
endinterface

// File: rtl/serial_shift_rx.sv
// serial_shift_rx
// Receives start + 8 data (+ optional even parity) + stop frames from an
// idle-high serial line, sampling once per DIV clock cycles, and hands each
// byte downstream over valid/ready. The last handshaken byte is mirrored onto
// an active-low LED bank.
// Optional feature: define SERIAL_SHIFT_RX_PARITY_EN to add an even parity bit
// between the data bits and the stop bit.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : serial_shift_rx_if.master
//            rx_in (in), ready_i (in), data_o/valid_o (byte handshake),
//            frame_err_o/parity_err_o (1-cycle pulses), overrun_o (sticky),
//            led_o (active-low copy of last transferred byte)
module serial_shift_rx #(
    parameter int unsigned DIV       = 1000,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    serial_shift_rx_if.master         bus
);

    localparam int unsigned CntW = $clog2(DIV);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shreg_q;
    logic            sync_q;
    logic            rx_s_q;
    logic            rx_prev_q;
    logic [7:0]      data_q;
    logic            valid_q;
    logic            frame_err_q;
    logic            overrun_q;
    logic [7:0]      led_q;
    logic            par_bad;

`ifdef SERIAL_SHIFT_RX_PARITY_EN
    logic            par_bad_q;
    logic            parity_err_q;
    assign par_bad = par_bad_q;
`else
    assign par_bad = 1'b0;
`endif

    logic rx_fall;
    logic xfer;

    assign rx_fall = rx_prev_q & ~rx_s_q;
    assign xfer    = valid_q & bus.ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            // Line idles high; resetting the synchronizer to 1 avoids a fake edge.
            sync_q       <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_prev_q    <= 1'b1;
            data_q       <= 8'h00;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            led_q        <= 8'hFF;
`ifdef SERIAL_SHIFT_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync_q      <= bus.rx_in;
            rx_s_q      <= sync_q;
            rx_prev_q   <= rx_s_q;
            frame_err_q <= 1'b0;
`ifdef SERIAL_SHIFT_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif

            if (xfer) begin
                valid_q   <= 1'b0;
                led_q     <= ~data_q;
                overrun_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (rx_fall) begin
                        state_q <= StStart;
                        cnt_q   <= CntW'(DIV / 2 - 1);
                    end
                end
                StStart: begin
                    if (cnt_q == '0) begin
                        if (rx_s_q) begin
                            state_q <= StIdle;
                        end else begin
                            state_q   <= StData;
                            cnt_q     <= CntW'(DIV - 1);
                            bit_cnt_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StData: begin
                    if (cnt_q == '0) begin
                        cnt_q <= CntW'(DIV - 1);
                        if (LSB_FIRST) begin
                            shreg_q <= {rx_s_q, shreg_q[7:1]};
                        end else begin
                            shreg_q <= {shreg_q[6:0], rx_s_q};
                        end
                        if (bit_cnt_q == 3'd7) begin
`ifdef SERIAL_SHIFT_RX_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StStop;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
`ifdef SERIAL_SHIFT_RX_PARITY_EN
                StParity: begin
                    if (cnt_q == '0) begin
                        cnt_q     <= CntW'(DIV - 1);
                        par_bad_q <= (^shreg_q) ^ rx_s_q;
                        state_q   <= StStop;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
`endif
                StStop: begin
                    if (cnt_q == '0) begin
                        state_q     <= StIdle;
                        frame_err_q <= ~rx_s_q;
`ifdef SERIAL_SHIFT_RX_PARITY_EN
                        parity_err_q <= par_bad_q;
`endif
                        if (rx_s_q && !par_bad) begin
                            // A same-cycle handshake frees the holding register,
                            // so the new byte loads (overriding the valid clear).
                            if (!valid_q || xfer) begin
                                data_q  <= shreg_q;
                                valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.data_o      = data_q;
    assign bus.valid_o     = valid_q;
    assign bus.frame_err_o = frame_err_q;
    assign bus.overrun_o   = overrun_q;
    assign bus.led_o       = led_q;
`ifdef SERIAL_SHIFT_RX_PARITY_EN
    assign bus.parity_err_o = parity_err_q;
`else
    assign bus.parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_serial_shift_rx.sv
module tb_serial_shift_rx;

    localparam int unsigned DIV = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    serial_shift_rx_if bus ();

    serial_shift_rx #(
        .DIV       (DIV),
        .LSB_FIRST (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: abstract per-frame view of the receiver outputs.
    logic [7:0] m_data    = 8'h00;
    logic [7:0] m_led     = 8'hFF;
    logic       m_valid   = 1'b0;
    logic       m_overrun = 1'b0;
    logic       rdy       = 1'b1;
    int         exp_ferr  = 0;
    int         exp_perr  = 0;
    logic [7:0] exp_q[$];

    // Observed pulse counts and transferred bytes.
    int         n_ferr = 0;
    int         n_perr = 0;
    logic [7:0] got_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.frame_err_o)  n_ferr++;
            if (bus.parity_err_o) n_perr++;
            if (bus.valid_o && bus.ready_i) got_q.push_back(bus.data_o);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data"},    32'(bus.data_o),    32'(m_data));
        check({tag, ".valid"},   32'(bus.valid_o),   32'(m_valid));
        check({tag, ".led"},     32'(bus.led_o),     32'(m_led));
        check({tag, ".overrun"}, 32'(bus.overrun_o), 32'(m_overrun));
        check({tag, ".ferr"},    32'(n_ferr),        32'(exp_ferr));
        check({tag, ".perr"},    32'(n_perr),        32'(exp_perr));
        check({tag, ".xfers"},   32'(got_q.size()),  32'(exp_q.size()));
    endtask

    task automatic hold_bit(input logic v);
        #1 bus.rx_in = v;
        repeat (DIV) @(posedge clk);
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop, input logic par);
        logic par_ok;
        par_ok = 1'b1;
`ifdef SERIAL_SHIFT_RX_PARITY_EN
        par_ok = ((^b) ^ par) == 1'b0;
`else
        par_ok = par | ~par;
`endif
        if (!stop)   exp_ferr++;
        if (!par_ok) exp_perr++;
        if (stop && par_ok) begin
            if (rdy) begin
                m_data = b;
                m_led  = ~b;
                exp_q.push_back(b);
            end else if (!m_valid) begin
                m_valid = 1'b1;
                m_data  = b;
            end else begin
                m_overrun = 1'b1;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(b[i]);
`ifdef SERIAL_SHIFT_RX_PARITY_EN
        hold_bit(par);
`endif
        hold_bit(stop);
        hold_bit(1'b1);
        model_frame(b, stop, par);
    endtask

    task automatic set_ready(input logic v);
        #1 bus.ready_i = v;
        rdy = v;
        if (v && m_valid) begin
            m_valid   = 1'b0;
            m_led     = ~m_data;
            m_overrun = 1'b0;
            exp_q.push_back(m_data);
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        logic [7:0] b;
        logic       stop;
        bus.rx_in   = 1'b1;
        bus.ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Basic byte with ready high: one-cycle valid, LEDs show ~byte.
        send_frame(8'hA5, 1'b1, ^8'hA5);
        check_all("a5");

        // Short low glitch on an idle line is a false start.
        #1 bus.rx_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.rx_in = 1'b1;
        repeat (3 * DIV) @(posedge clk);
        check_all("glitch");

        // Bad stop bit.
        send_frame(8'h3C, 1'b0, ^8'h3C);
        check_all("frame_err");

        // Overrun while the consumer stalls, then release.
        set_ready(1'b0);
        send_frame(8'h11, 1'b1, ^8'h11);
        send_frame(8'h22, 1'b1, ^8'h22);
        check_all("overrun");
        set_ready(1'b1);
        check_all("overrun_release");

        // Reset in the middle of data bit 4 of 0xFF.
        hold_bit(1'b0);
        for (int i = 0; i < 4; i++) hold_bit(1'b1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        m_data    = 8'h00;
        m_led     = 8'hFF;
        m_valid   = 1'b0;
        m_overrun = 1'b0;
        #1;
        check_all("mid_reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2 * DIV) @(posedge clk);
        check_all("post_reset_idle");
        send_frame(8'h81, 1'b1, ^8'h81);
        check_all("after_reset");

`ifdef SERIAL_SHIFT_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        check_all("parity_bad");
        set_ready(1'b0);
        send_frame(8'h07, 1'b1, 1'b1);
        check_all("parity_good");
        set_ready(1'b1);
        send_frame(8'h5A, 1'b0, 1'b1);
        check_all("parity_and_frame");
`endif

        // Randomized frames with occasional stop errors and ready toggling.
        for (int n = 0; n < 20; n++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) set_ready(~rdy);
            send_frame(b, stop, ($urandom_range(0, 4) == 0) ? ~(^b) : (^b));
            check_all($sformatf("rand%0d", n));
        end
        set_ready(1'b1);
        check_all("final");

        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
